// File: rtl/channel_merge_if.sv
// Bundle of the two producer streams, the merged consumer stream and the
// per-channel occupancy taps that connect to channel_merge.
//
// Handshake: every stream uses valid/ready. A beat transfers on a rising
// clk edge exactly when valid && ready are both high. A producer may change
// or drop valid and data while ready is low. Data is don't-care while valid
// is low. ready never depends combinationally on valid in this block.
interface channel_merge_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic              master_valid;
  logic              master_ready;
  logic [DATA_W-1:0] master_data;
  logic              slave_valid;
  logic              slave_ready;
  logic [DATA_W-1:0] slave_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_chan;
  logic [LW-1:0]     master_level;
  logic [LW-1:0]     slave_level;

  // Producer/consumer side: drives the input streams, accepts the merged one.
  modport master (
    output master_valid, master_data, slave_valid, slave_data, out_ready,
    input  master_ready, slave_ready, out_valid, out_data, out_chan,
           master_level, slave_level
  );

  // Merger side: the channel_merge block itself.
  modport slave (
    input  master_valid, master_data, slave_valid, slave_data, out_ready,
    output master_ready, slave_ready, out_valid, out_data, out_chan,
           master_level, slave_level
  );
endinterface

// File: rtl/channel_merge.sv
// Two-input stream merger: each input has its own DEPTH-entry FIFO, and a
// round-robin arbiter drains both into one registered output stream tagged
// with the source channel (0 = master, 1 = slave).
module channel_merge #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  channel_merge_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Channel index 0 is the master stream, index 1 is the slave stream.
  logic [1:0]        in_valid;
  logic [DATA_W-1:0] in_data [2];
  logic [1:0]        push;
  logic [1:0]        pop;
  logic [1:0]        non_empty;
  logic [1:0]        ready_q;

  logic [DATA_W-1:0] mem     [2][DEPTH];
  logic [AW-1:0]     wr_ptr  [2];
  logic [AW-1:0]     rd_ptr  [2];
  logic [LW-1:0]     level_q [2];
  logic [LW-1:0]     level_nx[2];

  logic              last_grant;
  logic              grant;
  logic              slot_free;
  logic [DATA_W-1:0] pop_data;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_chan_q;

  assign in_valid   = {bus.slave_valid, bus.master_valid};
  assign in_data[0] = bus.master_data;
  assign in_data[1] = bus.slave_data;

  // Arbitration, pop/push decisions and next occupancy per channel.
  always_comb begin
    slot_free = !out_valid_q || bus.out_ready;
    non_empty = '0;
    for (int c = 0; c < 2; c++) begin
      non_empty[c] = (level_q[c] != '0);
    end

    grant = 1'b0;
    if (&non_empty) begin
      grant = ~last_grant;
    end else if (non_empty[1]) begin
      grant = 1'b1;
    end

    pop = '0;
    if (slot_free && (|non_empty)) begin
      pop = grant ? 2'b10 : 2'b01;
    end

    push     = in_valid & ready_q;
    pop_data = mem[grant][rd_ptr[grant]];

    for (int c = 0; c < 2; c++) begin
      level_nx[c] = level_q[c] + LW'(push[c]) - LW'(pop[c]);
    end
  end

  // FIFO bookkeeping: pointers, occupancy, registered ready and last grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr[c]  <= '0;
        rd_ptr[c]  <= '0;
        level_q[c] <= '0;
      end
      ready_q    <= '0;
      last_grant <= 1'b1;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) begin
          wr_ptr[c] <= wr_ptr[c] + AW'(1);
        end
        if (pop[c]) begin
          rd_ptr[c] <= rd_ptr[c] + AW'(1);
        end
        level_q[c] <= level_nx[c];
        ready_q[c] <= (level_nx[c] < LW'(DEPTH));
      end
      if (|pop) begin
        last_grant <= grant;
      end
    end
  end

  // FIFO storage; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) begin
        mem[c][wr_ptr[c]] <= in_data[c];
      end
    end
  end

  // Output register: load on a free slot, go idle when nothing is queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= 1'b0;
    end else if (slot_free) begin
      if (|non_empty) begin
        out_valid_q <= 1'b1;
        out_data_q  <= pop_data;
        out_chan_q  <= grant;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.master_ready = ready_q[0];
  assign bus.slave_ready  = ready_q[1];
  assign bus.master_level = level_q[0];
  assign bus.slave_level  = level_q[1];
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_chan     = out_chan_q;
endmodule
